// File: rtl/miner_pkg.sv
// Shared miner types: nonce width and the latency-correction helper
// used by the compare stage, the golden nonce queue and the comm block.
package miner_pkg;

    localparam int NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    // Wraps mod 2^NONCE_W, so small nonces map to the top of the range.
    function automatic nonce_t correct_nonce(input nonce_t raw,
                                             input nonce_t offset);
        return raw - offset;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered head,
// occupancy counter and flush; flush has priority over push/pop.
module sync_fifo_fwft #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          hash_clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic          head_valid,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_nxt;
    logic [LW-1:0] level_nxt;
    logic [W-1:0]  head_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_nxt  = rd_ptr + AW'(1);

    always_comb begin
        level_nxt = level + LW'(push_ok) - LW'(pop_ok);
        head_nxt  = head;
        // Head register mirrors mem[rd_ptr]; refresh it whenever the head moves.
        if (pop_ok) begin
            head_nxt = (level == LW'(1)) ? push_data : mem[rd_nxt];
        end else if (empty && push_ok) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (!reset && !flush && push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset || flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            level      <= level_nxt;
            head       <= head_nxt;
            head_valid <= (level_nxt != '0);
        end
    end

endmodule

// File: rtl/golden_nonce_queue.sv
// Buffers latency-corrected golden-ticket nonces for the comm block
// and counts hits lost to a full queue.
module golden_nonce_queue
    import miner_pkg::*;
#(
    parameter int     DEPTH        = 8,
    parameter nonce_t NONCE_OFFSET = 32'd0,
    parameter int     CNT_W        = 8,
    localparam int    LW           = $clog2(DEPTH) + 1
) (
    input  logic             hash_clk,
    input  logic             reset,
    input  logic             hit,
    input  nonce_t           hit_nonce,
    input  logic             flush,
    output logic             out_valid,
    output nonce_t           out_nonce,
    input  logic             out_ack,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] overflow_cnt
);

    logic full;
    logic empty;
    logic pop;
    logic drop;

    assign pop  = out_ack & ~empty & ~flush;
    // A hit lost to flush is intentional, not an overflow.
    assign drop = hit & full & ~pop & ~flush;

    sync_fifo_fwft #(
        .W     (NONCE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .push       (hit & ~flush),
        .push_data  (correct_nonce(hit_nonce, NONCE_OFFSET)),
        .pop        (pop),
        .flush      (flush),
        .head       (out_nonce),
        .head_valid (out_valid),
        .level      (level),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != '1)) begin
            overflow_cnt <= overflow_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Directed bench: two queue instances (offset 3 / 2-bit counter and
// offset 5 / 8-bit counter) driven by the same stimulus.
module tb_golden_nonce_queue;

    logic        hash_clk = 1'b0;
    logic        reset    = 1'b0;
    logic        hit      = 1'b0;
    logic [31:0] hit_nonce = '0;
    logic        flush    = 1'b0;
    logic        out_ack  = 1'b0;

    logic        a_valid;
    logic [31:0] a_nonce;
    logic [3:0]  a_level;
    logic [1:0]  a_ovf;

    logic        b_valid;
    logic [31:0] b_nonce;
    logic [3:0]  b_level;
    logic [7:0]  b_ovf;

    int tests = 0;
    int fails = 0;

    always #5 hash_clk = ~hash_clk;

    golden_nonce_queue #(
        .DEPTH        (8),
        .NONCE_OFFSET (32'd3),
        .CNT_W        (2)
    ) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .hit          (hit),
        .hit_nonce    (hit_nonce),
        .flush        (flush),
        .out_valid    (a_valid),
        .out_nonce    (a_nonce),
        .out_ack      (out_ack),
        .level        (a_level),
        .overflow_cnt (a_ovf)
    );

    golden_nonce_queue #(
        .DEPTH        (8),
        .NONCE_OFFSET (32'd5),
        .CNT_W        (8)
    ) dut5 (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .hit          (hit),
        .hit_nonce    (hit_nonce),
        .flush        (flush),
        .out_valid    (b_valid),
        .out_nonce    (b_nonce),
        .out_ack      (out_ack),
        .level        (b_level),
        .overflow_cnt (b_ovf)
    );

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] drain_exp [8];

    initial begin
        drain_exp = '{32'd2, 32'd3, 32'd4, 32'd5,
                      32'd6, 32'd7, 32'd8, 32'hAA};

        // reset values
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_nonce", a_nonce, 32'd0);
        check("rst_level", 32'(a_level), 32'd0);
        check("rst_ovf",   32'(a_ovf), 32'd0);

        // single hit, one-cycle latency
        hit = 1'b1; hit_nonce = 32'h0000_0105;
        step();
        hit = 1'b0;
        check("single_valid", 32'(a_valid), 32'd1);
        check("single_nonce", a_nonce, 32'h0000_0102);
        check("single_level", 32'(a_level), 32'd1);
        check("single_nonce5", b_nonce, 32'h0000_0100);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("pop_valid", 32'(a_valid), 32'd0);
        check("pop_level", 32'(a_level), 32'd0);

        // empty ack ignored, subtraction wraps
        out_ack = 1'b1; hit = 1'b1; hit_nonce = 32'h0000_0002;
        step();
        hit = 1'b0; out_ack = 1'b0;
        check("wrap_nonce5", b_nonce, 32'hFFFF_FFFD);
        check("wrap_nonce3", a_nonce, 32'hFFFF_FFFF);
        check("wrap_level", 32'(a_level), 32'd1);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check("wrap_drained", 32'(a_level), 32'd0);

        // ten hits into an 8-deep queue
        for (int i = 1; i <= 10; i++) begin
            hit = 1'b1; hit_nonce = 32'(i);
            step();
        end
        hit = 1'b0;
        check("ovf_level", 32'(a_level), 32'd8);
        check("ovf_cnt", 32'(a_ovf), 32'd2);
        check("ovf_cnt5", 32'(b_ovf), 32'd2);
        check("ovf_head", a_nonce, 32'hFFFF_FFFE);

        // full with simultaneous push and pop
        hit = 1'b1; hit_nonce = 32'hAA; out_ack = 1'b1;
        step();
        hit = 1'b0; out_ack = 1'b0;
        check("fullpp_level", 32'(a_level), 32'd8);
        check("fullpp_cnt", 32'(a_ovf), 32'd2);

        // drain with continuous ack, no gaps
        out_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("drain_valid%0d", k), 32'(a_valid), 32'd1);
            check($sformatf("drain_nonce%0d", k), a_nonce,
                  drain_exp[k] - 32'd3);
            step();
        end
        out_ack = 1'b0;
        check("drain_empty", 32'(a_valid), 32'd0);
        check("drain_level", 32'(a_level), 32'd0);

        // flush beats hit and ack
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1; hit_nonce = 32'h10 + 32'(i);
            step();
        end
        hit = 1'b0;
        check("preflush_level", 32'(a_level), 32'd3);
        flush = 1'b1; hit = 1'b1; hit_nonce = 32'h99; out_ack = 1'b1;
        step();
        flush = 1'b0; hit = 1'b0; out_ack = 1'b0;
        check("flush_level", 32'(a_level), 32'd0);
        check("flush_valid", 32'(a_valid), 32'd0);
        check("flush_cnt", 32'(a_ovf), 32'd2);
        hit = 1'b1; hit_nonce = 32'h20;
        step();
        hit = 1'b0;
        check("postflush_valid", 32'(a_valid), 32'd1);
        check("postflush_nonce", a_nonce, 32'h1D);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;

        // counter saturation, then reset mid-drain
        for (int i = 0; i < 13; i++) begin
            hit = 1'b1; hit_nonce = 32'h30 + 32'(i);
            step();
        end
        hit = 1'b0;
        check("sat_cnt", 32'(a_ovf), 32'd3);
        check("sat_cnt5", 32'(b_ovf), 32'd7);
        check("sat_level", 32'(a_level), 32'd8);
        out_ack = 1'b1;
        step();
        step();
        check("middrain_nonce", a_nonce, 32'h2F);
        check("middrain_level", 32'(a_level), 32'd6);
        reset = 1'b1; hit = 1'b1; hit_nonce = 32'h77;
        step();
        reset = 1'b0; hit = 1'b0; out_ack = 1'b0;
        check("rst2_valid", 32'(a_valid), 32'd0);
        check("rst2_nonce", a_nonce, 32'd0);
        check("rst2_level", 32'(a_level), 32'd0);
        check("rst2_ovf", 32'(a_ovf), 32'd0);
        check("rst2_ovf5", 32'(b_ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/golden_nonce_queue.md
Name: golden_nonce_queue

Overview:
- Sits directly downstream of the hasher's golden-ticket compare stage, in the hash_clk domain.
- Captures every golden-ticket hit and applies a fixed pipeline-latency correction to the nonce.
- Buffers corrected nonces in a small FIFO and presents them one at a time to the communication block via a valid/ack handshake.
- Prevents loss of back-to-back hits that would otherwise be overwritten before the comm block samples them.

Parameters:
- DEPTH, 8: number of nonce entries. Must be a power of two, 2..64.
- NONCE_OFFSET, 32'd0: constant subtracted (mod 2^32) from the incoming nonce to compensate for hasher pipeline latency.
- CNT_W, 8: width of the saturating overflow counter.

Ports:
- hash_clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- hit  in  1  single-cycle golden-ticket strobe from the compare stage.
- hit_nonce  in  32  raw nonce qualified by hit.
- flush  in  1  new-work strobe; discards all queued nonces.
- out_valid  out  1  head entry available.
- out_nonce  out  32  corrected nonce at the head; stable while out_valid=1 and out_ack=0.
- out_ack  in  1  consumer pops the head when out_valid=1; ignored when out_valid=0.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_cnt  out  CNT_W  saturating count of hits dropped because the queue was full.

Behaviour:
- Reset (sync, 1 cycle): out_valid=0, out_nonce=0, level=0, overflow_cnt=0, read/write pointers=0. Storage contents are don't-care.
- Nonce correction: stored value = hit_nonce - NONCE_OFFSET, 32-bit wrap (e.g. 0x00000002 - 5 = 0xFFFFFFFD). Subtraction is done at write time.
- Latency: hit at edge N with the queue empty -> out_valid=1 and out_nonce valid after edge N+1 (one cycle). No combinational path from hit to out_valid.
- Output register: out_nonce and out_valid are registered. The head is first-word-fall-through: after a pop, the next entry appears at the following edge with no bubble when level>1.
- Push: accepted when hit=1 and (level<DEPTH, or out_ack=1 with out_valid=1).
- Pop: occurs when out_ack=1 and out_valid=1.
- Full with simultaneous hit and pop: both take effect; level is unchanged; no overflow is counted.
- Full with hit and no pop: the new nonce is dropped and the existing entries are kept. overflow_cnt increments and saturates at all-ones; it never wraps.
- Empty with simultaneous hit and out_ack: the ack is ignored because out_valid=0. The hit is queued normally.
- Flush: highest priority after reset. The cycle after flush, level=0 and out_valid=0. A hit in the same cycle as flush is discarded and not counted as overflow. out_ack in the same cycle is ignored. overflow_cnt is not cleared by flush, only by reset.
- Pointers: log2(DEPTH)-bit wrapping read/write pointers plus a separate occupancy counter. Full is level==DEPTH; empty is level==0.
- Mid-operation reset: overrides everything, including a pending hit, ack or flush, and produces the reset values above.

Decomposition:
- Shared package (miner_pkg): NONCE_W=32 constant and nonce_t typedef, reused by the compare stage and the comm interface.
- One natural sub-module: sync_fifo_fwft (generic width/depth, synchronous first-word-fall-through FIFO with push/pop/flush, level, full, empty). It is reused later for the work queue.
- The top level adds only the offset subtract, overflow counter and flush priority logic.

Test Plan:
- Single hit, NONCE_OFFSET=3: reset, then hit with hit_nonce=0x00000105 -> next cycle out_valid=1, out_nonce=0x00000102, level=1. Then out_ack=1 -> out_valid=0, level=0.
- Wrap: NONCE_OFFSET=5, hit_nonce=0x00000002 -> out_nonce=0xFFFFFFFD.
- Overflow: DEPTH=8, 10 consecutive hits with nonces 1..10 and no ack -> level=8, overflow_cnt=2. Draining with continuous out_ack yields 1..8 in order, one per cycle with no gaps.
- Full with simultaneous push/pop: queue full, then hit (0xAA) together with out_ack -> level stays 8, overflow_cnt unchanged, 0xAA is the last value drained.
- Flush priority: 3 entries queued, then flush together with hit and out_ack -> next cycle level=0, out_valid=0, overflow_cnt unchanged. A later hit is delivered normally.
- Saturation and reset: CNT_W=2, 5 dropped hits -> overflow_cnt=3. Asserting reset mid-drain -> all outputs are 0 at the next edge.
